// File: rtl/lock_fsm.sv
// rtl/lock_fsm.sv - password lock controller with open timeout and wrong-entry alarm
module lock_fsm #(
    parameter logic [3:0]  PWD_INIT  = 4'h5,
    parameter logic [1:0]  MAX_ERR   = 2'd3,
    parameter logic [27:0] OPEN_CYC  = 28'd135_000_000,
    parameter logic [27:0] ALARM_CYC = 28'd81_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ctrl,
    input  logic       enter_trig,
    input  logic       init_trig,
    output logic [1:0] state,
    output logic       unlock,
    output logic       alarm,
    output logic [1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_LOCKED = 2'b00,
        ST_OPEN   = 2'b01,
        ST_ALARM  = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    localparam logic [27:0] OPEN_LAST  = OPEN_CYC - 28'd1;
    localparam logic [27:0] ALARM_LAST = ALARM_CYC - 28'd1;
    localparam logic [2:0]  ERR_LIMIT  = {1'b0, MAX_ERR};

    state_t      state_q, state_d;
    logic [1:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  pwd_q, pwd_d;
    logic [27:0] tmr_q, tmr_d;
    logic [2:0]  err_inc;

    // Widened so the +1 never wraps before being compared with the limit.
    assign err_inc = {1'b0, err_cnt_q} + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOCKED;
            err_cnt_q <= 2'd0;
            pwd_q     <= PWD_INIT;
            tmr_q     <= 28'd0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
            pwd_q     <= pwd_d;
            tmr_q     <= tmr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_cnt_d = err_cnt_q;
        pwd_d     = pwd_q;
        tmr_d     = tmr_q;

        case (state_q)
            ST_LOCKED: begin
                tmr_d = 28'd0;
                // init_trig is a no-op here but still swallows a coincident enter.
                if (!init_trig && enter_trig) begin
                    if (ctrl == pwd_q) begin
                        state_d   = ST_OPEN;
                        err_cnt_d = 2'd0;
                    end else if (err_inc >= ERR_LIMIT) begin
                        state_d   = ST_ALARM;
                        err_cnt_d = MAX_ERR;
                    end else begin
                        err_cnt_d = err_inc[1:0];
                    end
                end
            end

            ST_OPEN: begin
                if (init_trig) begin
                    state_d = ST_LOCKED;
                    tmr_d   = 28'd0;
                end else if (enter_trig) begin
                    state_d = ST_LOCKED;
                    pwd_d   = ctrl;
                    tmr_d   = 28'd0;
                end else if (tmr_q >= OPEN_LAST) begin
                    state_d = ST_LOCKED;
                    tmr_d   = 28'd0;
                end else begin
                    tmr_d = tmr_q + 28'd1;
                end
            end

            ST_ALARM: begin
                // Keys are deliberately ignored until the alarm period runs out.
                if (tmr_q >= ALARM_LAST) begin
                    state_d   = ST_LOCKED;
                    err_cnt_d = 2'd0;
                    tmr_d     = 28'd0;
                end else begin
                    tmr_d = tmr_q + 28'd1;
                end
            end

            default: begin
                state_d   = ST_LOCKED;
                err_cnt_d = 2'd0;
                tmr_d     = 28'd0;
            end
        endcase
    end

    assign state   = state_q;
    assign unlock  = (state_q == ST_OPEN);
    assign alarm   = (state_q == ST_ALARM);
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lock_fsm.sv
// tb/tb_lock_fsm.sv - directed self-checking bench for lock_fsm
module tb_lock_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] ctrl = 4'h0;
    logic       enter_trig = 1'b0;
    logic       init_trig = 1'b0;
    logic [1:0] state;
    logic       unlock;
    logic       alarm;
    logic [1:0] err_cnt;

    int errors = 0;
    int checks = 0;

    lock_fsm #(
        .PWD_INIT (4'h5),
        .MAX_ERR  (2'd3),
        .OPEN_CYC (28'd10),
        .ALARM_CYC(28'd8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl      (ctrl),
        .enter_trig(enter_trig),
        .init_trig (init_trig),
        .state     (state),
        .unlock    (unlock),
        .alarm     (alarm),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ctrl = 4'h0;
        enter_trig = 1'b0;
        init_trig = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_enter(input logic [3:0] code);
        @(negedge clk);
        ctrl = code;
        enter_trig = 1'b1;
        @(negedge clk);
        enter_trig = 1'b0;
    endtask

    task automatic press_init();
        @(negedge clk);
        init_trig = 1'b1;
        @(negedge clk);
        init_trig = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
        checks++; if (unlock !== 1'b0 || alarm !== 1'b0) begin errors++; $display("FAIL reset_flags: got unlock=%b alarm=%b expected 0 0", unlock, alarm); end
        checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected 00", state); end
    endtask

    task automatic test_open_duration();
        int cnt;
        int guard;
        do_reset();
        press_enter(4'h5);
        checks++; if (state !== 2'b01 || unlock !== 1'b1 || alarm !== 1'b0) begin errors++; $display("FAIL open_enter: got state=%b unlock=%b alarm=%b expected 01 1 0", state, unlock, alarm); end
        cnt = 1;
        guard = 0;
        while (state == 2'b01 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (state == 2'b01) cnt++;
        end
        checks++; if (cnt !== 10) begin errors++; $display("FAIL open_length: got %0d cycles expected 10", cnt); end
        checks++; if (state !== 2'b00 || unlock !== 1'b0) begin errors++; $display("FAIL open_exit: got state=%b unlock=%b expected 00 0", state, unlock); end
    endtask

    task automatic test_alarm();
        int cnt;
        int guard;
        do_reset();
        press_enter(4'h3);
        checks++; if (err_cnt !== 2'd1 || state !== 2'b00) begin errors++; $display("FAIL alarm_err1: got err=%0d state=%b expected 1 00", err_cnt, state); end
        press_enter(4'h3);
        checks++; if (err_cnt !== 2'd2 || state !== 2'b00) begin errors++; $display("FAIL alarm_err2: got err=%0d state=%b expected 2 00", err_cnt, state); end
        press_enter(4'h3);
        checks++; if (state !== 2'b10 || alarm !== 1'b1 || unlock !== 1'b0) begin errors++; $display("FAIL alarm_enter: got state=%b alarm=%b unlock=%b expected 10 1 0", state, alarm, unlock); end
        checks++; if (err_cnt !== 2'd3) begin errors++; $display("FAIL alarm_err_hold: got %0d expected 3", err_cnt); end
        cnt = 1;
        guard = 0;
        while (state == 2'b10 && guard < 40) begin
            ctrl = 4'h5;
            enter_trig = (cnt == 2 || cnt == 3);
            init_trig = (cnt == 5);
            @(negedge clk);
            enter_trig = 1'b0;
            init_trig = 1'b0;
            guard++;
            if (state == 2'b10) cnt++;
        end
        checks++; if (cnt !== 8) begin errors++; $display("FAIL alarm_length: got %0d cycles expected 8", cnt); end
        checks++; if (state !== 2'b00 || alarm !== 1'b0 || err_cnt !== 2'd0) begin errors++; $display("FAIL alarm_exit: got state=%b alarm=%b err=%0d expected 00 0 0", state, alarm, err_cnt); end
    endtask

    task automatic test_pwd_change();
        do_reset();
        press_enter(4'h5);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL pwd_open: got %b expected 01", state); end
        press_enter(4'hA);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL pwd_relock: got %b expected 00", state); end
        press_enter(4'h5);
        checks++; if (err_cnt !== 2'd1 || state !== 2'b00) begin errors++; $display("FAIL pwd_old_rejected: got err=%0d state=%b expected 1 00", err_cnt, state); end
        press_enter(4'hA);
        checks++; if (state !== 2'b01 || err_cnt !== 2'd0) begin errors++; $display("FAIL pwd_new_accepted: got state=%b err=%0d expected 01 0", state, err_cnt); end
    endtask

    task automatic test_err_clear();
        do_reset();
        press_enter(4'h3);
        press_enter(4'h7);
        checks++; if (err_cnt !== 2'd2) begin errors++; $display("FAIL errclr_two: got %0d expected 2", err_cnt); end
        press_enter(4'h5);
        checks++; if (state !== 2'b01 || err_cnt !== 2'd0) begin errors++; $display("FAIL errclr_open: got state=%b err=%0d expected 01 0", state, err_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_enter(4'h3);
        @(negedge clk);
        ctrl = 4'h5;
        enter_trig = 1'b1;
        init_trig = 1'b1;
        @(negedge clk);
        enter_trig = 1'b0;
        init_trig = 1'b0;
        checks++; if (state !== 2'b00 || err_cnt !== 2'd1) begin errors++; $display("FAIL both_locked: got state=%b err=%0d expected 00 1", state, err_cnt); end
        press_init();
        checks++; if (state !== 2'b00 || err_cnt !== 2'd1) begin errors++; $display("FAIL init_locked: got state=%b err=%0d expected 00 1", state, err_cnt); end
        press_enter(4'h5);
        press_init();
        checks++; if (state !== 2'b00 || unlock !== 1'b0) begin errors++; $display("FAIL init_open: got state=%b unlock=%b expected 00 0", state, unlock); end
        press_enter(4'h5);
        @(negedge clk);
        ctrl = 4'h9;
        enter_trig = 1'b1;
        init_trig = 1'b1;
        @(negedge clk);
        enter_trig = 1'b0;
        init_trig = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL both_open: got %b expected 00", state); end
        press_enter(4'h5);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL both_open_pwd_kept: got %b expected 01", state); end
    endtask

    task automatic test_expiry_trigger();
        do_reset();
        press_enter(4'h5);
        repeat (9) @(negedge clk);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL expiry_last_cycle: got %b expected 01", state); end
        ctrl = 4'hC;
        enter_trig = 1'b1;
        @(negedge clk);
        enter_trig = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL expiry_enter_lock: got %b expected 00", state); end
        press_enter(4'h5);
        checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL expiry_pwd_changed: got err=%0d expected 1", err_cnt); end
        press_enter(4'hC);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL expiry_new_pwd: got %b expected 01", state); end
    endtask

    task automatic test_async_reset();
        do_reset();
        press_enter(4'h3);
        press_enter(4'h3);
        press_enter(4'h3);
        @(negedge clk);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL areset_in_alarm: got %b expected 10", state); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'b00 || alarm !== 1'b0 || unlock !== 1'b0 || err_cnt !== 2'd0) begin errors++; $display("FAIL areset_immediate: got state=%b alarm=%b unlock=%b err=%0d expected 00 0 0 0", state, alarm, unlock, err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        press_enter(4'h5);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL areset_reopen: got %b expected 01", state); end
    endtask

    task automatic test_pwd_lost();
        do_reset();
        press_enter(4'h5);
        press_enter(4'hB);
        do_reset();
        press_enter(4'hB);
        checks++; if (state !== 2'b00 || err_cnt !== 2'd1) begin errors++; $display("FAIL lost_old_pwd: got state=%b err=%0d expected 00 1", state, err_cnt); end
        press_enter(4'h5);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL lost_init_pwd: got %b expected 01", state); end
    endtask

    initial begin
        test_reset();
        test_open_duration();
        test_alarm();
        test_pwd_change();
        test_err_clear();
        test_simultaneous();
        test_expiry_trigger();
        test_async_reset();
        test_pwd_lost();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lock_fsm.md
LOCK_FSM -- requirements
Module: lock_fsm

Interface
REQ-001 Parameter PWD_INIT, 4'h5, password value loaded at reset.
REQ-002 Parameter MAX_ERR, 2'd3, number of consecutive wrong entries that triggers alarm (legal range 1..3).
REQ-003 Parameter OPEN_CYC, 28'd135_000_000, open-state duration in clk cycles (5 s at 27 MHz); legal range >= 2.
REQ-004 Parameter ALARM_CYC, 28'd81_000_000, alarm-state duration in clk cycles (3 s at 27 MHz); legal range >= 2.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 ctrl  input  4  current code from the key-counter stage, {key2_cnt, key1_cnt}.
REQ-008 enter_trig  input  1  single-cycle pulse: submit ctrl.
REQ-009 init_trig  input  1  single-cycle pulse: cancel / relock.
REQ-010 state  output  2  current state: 2'b00 LOCKED, 2'b01 OPEN, 2'b10 ALARM.
REQ-011 unlock  output  1  high while in OPEN.
REQ-012 alarm  output  1  high while in ALARM.
REQ-013 err_cnt  output  2  consecutive wrong-entry count.

Function
REQ-014 All outputs SHALL be registered; every response appears on the first clk edge after the triggering input cycle (latency 1).
REQ-015 Internal 4-bit password register pwd and 28-bit timer tmr SHALL be provided.
REQ-016 LOCKED, enter_trig, ctrl == pwd: go OPEN, err_cnt <= 0, tmr <= 0.
REQ-017 LOCKED, enter_trig, ctrl != pwd, err_cnt+1 < MAX_ERR: stay LOCKED, err_cnt <= err_cnt+1.
REQ-018 LOCKED, enter_trig, ctrl != pwd, err_cnt+1 == MAX_ERR: go ALARM, tmr <= 0, err_cnt <= MAX_ERR (held during ALARM).
REQ-019 LOCKED, init_trig: no state change; err_cnt unchanged.
REQ-020 OPEN, enter_trig: pwd <= ctrl (password change), go LOCKED.
REQ-021 OPEN, init_trig: go LOCKED, pwd unchanged.
REQ-022 OPEN, no trigger: tmr increments each cycle; when tmr == OPEN_CYC-1, go LOCKED next edge (OPEN lasts exactly OPEN_CYC cycles).
REQ-023 ALARM: enter_trig and init_trig SHALL be ignored; tmr increments; when tmr == ALARM_CYC-1, go LOCKED with err_cnt <= 0 (ALARM lasts exactly ALARM_CYC cycles).
REQ-024 enter_trig and init_trig in the same cycle: init_trig SHALL take priority, enter_trig discarded.
REQ-025 Trigger arriving on the same cycle as timer expiry in OPEN: trigger action SHALL take precedence (REQ-020/021); result state is LOCKED either way.
REQ-026 tmr SHALL hold 0 in LOCKED and never wrap; comparisons use full 28-bit width.
REQ-027 Unencoded state 2'b11 SHALL transition to LOCKED on the next edge with err_cnt <= 0.
REQ-028 unlock and alarm SHALL be decoded from the state register, never both high.

Reset
REQ-029 rst_n low SHALL immediately, regardless of clk, force state = LOCKED, unlock = 0, alarm = 0, err_cnt = 0, tmr = 0, pwd = PWD_INIT.
REQ-030 Reset asserted mid-OPEN or mid-ALARM SHALL abort the timer; after release, a password changed in OPEN is lost (pwd = PWD_INIT).
REQ-031 First active edge after rst_n deasserts SHALL obey REQ-016..REQ-027 normally.

Verification (bench uses OPEN_CYC = 10, ALARM_CYC = 8, MAX_ERR = 3)
REQ-032 Reset, ctrl = 4'h5, enter_trig pulse -> next edge state = 01, unlock = 1; held exactly 10 cycles, then state = 00.
REQ-033 ctrl = 4'h3, three enter_trig pulses -> err_cnt 1, 2, then state = 10, alarm = 1 for exactly 8 cycles; enter_trig during alarm ignored; exit with err_cnt = 0.
REQ-034 Unlock with 4'h5, then ctrl = 4'hA + enter_trig -> LOCKED; ctrl = 4'h5 enter -> err_cnt = 1; ctrl = 4'hA enter -> OPEN.
REQ-035 Two wrong entries (err_cnt = 2), then correct entry -> OPEN, err_cnt = 0.
REQ-036 In LOCKED, enter_trig and init_trig same cycle with ctrl = 4'h5 -> state stays 00; in OPEN, init_trig -> state 00 next edge.
REQ-037 rst_n pulsed low mid-ALARM (async, between edges) -> outputs 0 immediately; after release, ctrl = 4'h5 enter -> OPEN.
